// File: rtl/sim_step_ctrl.sv
// sim_step_ctrl: runs deposit -> solve -> push phase triplets for a requested timestep count,
// with abort-after-current-step, per-phase timeout and UI memory lock while busy.
module sim_step_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ui_go_wr,
    input  logic [31:0] ui_go_wdata,
    output logic        dep_start,
    output logic        slv_start,
    output logic        push_start,
    input  logic        dep_done,
    input  logic        slv_done,
    input  logic        push_done,
    output logic        busy,
    output logic        ui_mem_lock,
    output logic [31:0] steps_left,
    output logic [31:0] steps_done,
    output logic        run_done,
    output logic        timeout_err
);
    typedef enum logic [2:0] {IDLE, DEP, DEP_W, SLV, SLV_W, PUSH, PUSH_W, FIN} state_t;
    localparam logic [31:0] TMAX = 32'(TIMEOUT_CYCLES - 1);
    state_t      state, state_nx;
    logic        abort_pending;
    logic [31:0] timer;
    logic        accept, abort_req, waiting, phase_done, expired, step_fire;
    logic [31:0] left_dec;
    assign accept     = state == IDLE && ui_go_wr && ui_go_wdata != '0;
    assign abort_req  = state != IDLE && ui_go_wr && ui_go_wdata == '0;
    assign waiting    = state inside {DEP_W, SLV_W, PUSH_W};
    assign phase_done = (state == DEP_W && dep_done) || (state == SLV_W && slv_done) ||
                        (state == PUSH_W && push_done);
    assign expired    = waiting && !phase_done && timer >= TMAX;
    assign step_fire  = state == PUSH_W && push_done;
    assign left_dec   = steps_left - 32'(steps_left != '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            steps_left    <= '0;
            steps_done    <= '0;
            timeout_err   <= 1'b0;
            abort_pending <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= waiting ? timer + 32'd1 : '0;
            if (accept) begin
                steps_left    <= ui_go_wdata;
                steps_done    <= '0;
                timeout_err   <= 1'b0;
                abort_pending <= 1'b0;
            end else begin
                if (abort_req) abort_pending <= 1'b1;
                if (state == FIN) abort_pending <= 1'b0;
                if (expired) timeout_err <= 1'b1;
                if (step_fire) begin
                    steps_left <= left_dec;
                    steps_done <= steps_done + 32'(steps_done != '1);
                end
            end
        end
    end
    // an abort arriving together with push_done still ends the run after this step
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? DEP : IDLE;
            DEP:     state_nx = DEP_W;
            DEP_W:   state_nx = dep_done ? SLV : expired ? FIN : DEP_W;
            SLV:     state_nx = SLV_W;
            SLV_W:   state_nx = slv_done ? PUSH : expired ? FIN : SLV_W;
            PUSH:    state_nx = PUSH_W;
            PUSH_W:  state_nx = push_done ? ((left_dec != '0 && !abort_pending && !abort_req) ? DEP : FIN)
                                          : expired ? FIN : PUSH_W;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        dep_start   = state == DEP;
        slv_start   = state == SLV;
        push_start  = state == PUSH;
        run_done    = state == FIN;
        busy        = state != IDLE;
        ui_mem_lock = state != IDLE;
    end
endmodule

// File: tb/tb_sim_step_ctrl.sv
// tb_sim_step_ctrl: randomized phase-handshake runs checked cycle by cycle against a protocol-level model.
module tb_sim_step_ctrl;
    logic        clk = 1'b0, rst = 1'b1, ui_go_wr = 1'b0;
    logic        dep_done = 1'b0, slv_done = 1'b0, push_done = 1'b0;
    logic [31:0] ui_go_wdata = '0;
    logic        dep_start, slv_start, push_start, busy, ui_mem_lock, run_done, timeout_err;
    logic [31:0] steps_left, steps_done;
    int          checks = 0, errors = 0;

    sim_step_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .ui_go_wr(ui_go_wr), .ui_go_wdata(ui_go_wdata),
        .dep_start(dep_start), .slv_start(slv_start), .push_start(push_start),
        .dep_done(dep_done), .slv_done(slv_done), .push_done(push_done),
        .busy(busy), .ui_mem_lock(ui_mem_lock), .steps_left(steps_left),
        .steps_done(steps_done), .run_done(run_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // pulses seen this cycle as {dep_start, slv_start, push_start, run_done}
    function automatic logic [3:0] evt();
        return {dep_start, slv_start, push_start, run_done};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic go(input logic [31:0] w);
        ui_go_wr = 1'b1;
        ui_go_wdata = w;
        cyc();
        ui_go_wr = 1'b0;
        ui_go_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {ui_go_wr, dep_done, slv_done, push_done} = '0;
        ui_go_wdata = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ui_go_wr = 1'b1;
        ui_go_wdata = 32'd9;
        dep_done = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({evt(), busy, ui_mem_lock, timeout_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0", {evt(), busy, ui_mem_lock, timeout_err});
        end
        checks++;
        if (steps_left !== 32'd0 || steps_done !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got left=%0d done=%0d exp 0/0", steps_left, steps_done);
        end
        rst = 1'b0;
        ui_go_wr = 1'b0;
        ui_go_wdata = '0;
        dep_done = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || evt() !== 4'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b evt=%b exp 0", busy, evt());
        end
    endtask

    // dly = 0 selects random done latency, spurious dones and ignored nonzero gos
    task automatic test_run(input int n, input int abort_step, input int dly);
        logic [3:0] exp_ev;
        logic [2:0] oh;
        int         phase, cnt, rem, dn, q;
        bit         abort_sent, fin;
        phase = 0; cnt = 0; rem = n; dn = 0; abort_sent = 0; fin = 0;
        exp_ev = 4'b1000;
        ui_go_wr = 1'b1;
        ui_go_wdata = 32'(n);
        for (int c = 0; c < 2000 && !fin; c++) begin
            cyc();
            ui_go_wr = 1'b0;
            ui_go_wdata = '0;
            {dep_done, slv_done, push_done} = '0;
            checks++;
            if (evt() !== exp_ev) begin
                errors++;
                $display("FAIL run_pulses n=%0d cyc=%0d got %b exp %b", n, c, evt(), exp_ev);
            end
            checks++;
            if (busy !== 1'b1 || ui_mem_lock !== 1'b1 || steps_left !== 32'(rem) || steps_done !== 32'(dn)) begin
                errors++;
                $display("FAIL run_state n=%0d cyc=%0d got busy=%b lock=%b left=%0d done=%0d exp 1/1/%0d/%0d",
                         n, c, busy, ui_mem_lock, steps_left, steps_done, rem, dn);
            end
            fin = exp_ev[0];
            if (exp_ev[3:1] != 3'b0) begin
                phase = exp_ev[3] ? 1 : exp_ev[2] ? 2 : 3;
                cnt = dly != 0 ? dly : $urandom_range(1, 6);
            end
            exp_ev = 4'b0;
            if (!fin && phase != 0) begin
                if (dly == 0 && $urandom_range(0, 3) == 0) begin
                    q = $urandom_range(1, 3);
                    oh = 3'b100 >> (q - 1);
                    if (q != phase) {dep_done, slv_done, push_done} = oh;
                end
                if (cnt == 0) begin
                    oh = 3'b100 >> (phase - 1);
                    {dep_done, slv_done, push_done} = {dep_done, slv_done, push_done} | oh;
                    if (phase == 2 && abort_step != 0 && !abort_sent && dn == abort_step - 1) begin
                        ui_go_wr = 1'b1;
                        ui_go_wdata = '0;
                        abort_sent = 1;
                    end
                    if (phase == 3) begin
                        dn++;
                        rem--;
                        exp_ev = (rem != 0 && !abort_sent) ? 4'b1000 : 4'b0001;
                    end else begin
                        exp_ev = phase == 1 ? 4'b0100 : 4'b0010;
                    end
                    phase = 0;
                end else begin
                    cnt--;
                end
                if (dly == 0 && !ui_go_wr && $urandom_range(0, 7) == 0) begin
                    ui_go_wr = 1'b1;
                    ui_go_wdata = 32'($urandom_range(1, 50));
                end
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL run_no_finish n=%0d got no run_done exp run_done", n);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || ui_mem_lock !== 1'b0 || evt() !== 4'b0 || steps_left !== 32'(rem) || steps_done !== 32'(dn)) begin
            errors++;
            $display("FAIL run_end n=%0d got busy=%b lock=%b evt=%b left=%0d done=%0d exp 0/0/0000/%0d/%0d",
                     n, busy, ui_mem_lock, evt(), steps_left, steps_done, rem, dn);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        go(32'd2);
        checks++;
        if (evt() !== 4'b1000) begin
            errors++;
            $display("FAIL spur_dep_start got %b exp 1000", evt());
        end
        dep_done = 1'b1;
        cyc();
        dep_done = 1'b0;
        checks++;
        if (evt() !== 4'b0000) begin
            errors++;
            $display("FAIL spur_same_cycle_done got %b exp 0000", evt());
        end
        push_done = 1'b1;
        cyc();
        push_done = 1'b0;
        checks++;
        if (evt() !== 4'b0000 || steps_done !== 32'd0 || steps_left !== 32'd2) begin
            errors++;
            $display("FAIL spur_push_done got evt=%b left=%0d done=%0d exp 0000/2/0", evt(), steps_left, steps_done);
        end
        dep_done = 1'b1;
        cyc();
        dep_done = 1'b0;
        checks++;
        if (evt() !== 4'b0100) begin
            errors++;
            $display("FAIL spur_late_dep_done got %b exp 0100", evt());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        go(32'd1);
        checks++;
        if (evt() !== 4'b1000) begin
            errors++;
            $display("FAIL to_dep_start got %b exp 1000", evt());
        end
        cyc();
        dep_done = 1'b1;
        cyc();
        dep_done = 1'b0;
        checks++;
        if (evt() !== 4'b0100) begin
            errors++;
            $display("FAIL to_slv_start got %b exp 0100", evt());
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            checks++;
            if (evt() !== 4'b0000 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL to_wait w=%0d got evt=%b err=%b exp 0000/0", i, evt(), timeout_err);
            end
        end
        cyc();
        checks++;
        if (evt() !== 4'b0001 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_fin got evt=%b err=%b exp 0001/1", evt(), timeout_err);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || steps_done !== 32'd0 || steps_left !== 32'd1) begin
            errors++;
            $display("FAIL to_idle got busy=%b err=%b left=%0d done=%0d exp 0/1/1/0", busy, timeout_err, steps_left, steps_done);
        end
        go(32'd1);
        checks++;
        if (evt() !== 4'b1000 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got evt=%b err=%b exp 1000/0", evt(), timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        go(32'd5);
        cyc();
        dep_done = 1'b1;
        cyc();
        dep_done = 1'b0;
        cyc();
        slv_done = 1'b1;
        cyc();
        slv_done = 1'b0;
        checks++;
        if (evt() !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_push_start got %b exp 0010", evt());
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({evt(), busy, ui_mem_lock, timeout_err} !== 7'b0 || steps_left !== 32'd0 || steps_done !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got evt=%b busy=%b left=%0d done=%0d exp all 0", evt(), busy, steps_left, steps_done);
        end
        push_done = 1'b1;
        cyc();
        push_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (evt() !== 4'b0 || busy !== 1'b0 || steps_done !== 32'd0) begin
                errors++;
                $display("FAIL rstmid_after i=%0d got evt=%b busy=%b done=%0d exp 0/0/0", i, evt(), busy, steps_done);
            end
            cyc();
        end
    endtask

    task automatic test_ignored_go();
        do_reset();
        test_run(1, 0, 2);
        go(32'd0);
        checks++;
        if (busy !== 1'b0 || evt() !== 4'b0 || steps_left !== 32'd0 || steps_done !== 32'd1) begin
            errors++;
            $display("FAIL ign_zero_go got busy=%b evt=%b left=%0d done=%0d exp 0/0000/0/1", busy, evt(), steps_left, steps_done);
        end
        go(32'd4);
        cyc();
        go(32'd7);
        checks++;
        if (busy !== 1'b1 || evt() !== 4'b0 || steps_left !== 32'd4 || steps_done !== 32'd0) begin
            errors++;
            $display("FAIL ign_busy_go got busy=%b evt=%b left=%0d done=%0d exp 1/0000/4/0", busy, evt(), steps_left, steps_done);
        end
        dep_done = 1'b1;
        cyc();
        dep_done = 1'b0;
        checks++;
        if (evt() !== 4'b0100 || steps_left !== 32'd4) begin
            errors++;
            $display("FAIL ign_continue got evt=%b left=%0d exp 0100/4", evt(), steps_left);
        end
    endtask

    initial begin
        int n;
        test_reset();
        test_run(3, 0, 5);
        test_run(10, 2, 0);
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 8);
            test_run(n, ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0, 0);
        end
        test_spurious();
        test_timeout();
        test_reset_mid();
        test_ignored_go();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sim_step_ctrl.md
SIM_STEP_CTRL -- requirements
Module: sim_step_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, max cycles to wait for any one phase done.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port ui_go_wr  input  1  single-cycle go strobe from UI command parser.
REQ-005 SHALL have port ui_go_wdata  input  32  requested timestep count; 0 = abort.
REQ-006 SHALL have ports dep_start, slv_start, push_start  output  1 each  single-cycle phase start pulses: charge deposit, field solve, particle push.
REQ-007 SHALL have ports dep_done, slv_done, push_done  input  1 each  single-cycle phase completion pulses.
REQ-008 SHALL have port busy  output  1  high while a run is in progress.
REQ-009 SHALL have port ui_mem_lock  output  1  equals busy; blocks UI mag/chrg/phi accesses.
REQ-010 SHALL have port steps_left  output  32  timesteps remaining in current run.
REQ-011 SHALL have port steps_done  output  32  timesteps completed since last accepted go.
REQ-012 SHALL have port run_done  output  1  single-cycle pulse when a run ends, normal or aborted.
REQ-013 SHALL have port timeout_err  output  1  sticky phase-timeout flag.

Function
REQ-014 SHALL implement states IDLE, DEP, DEP_W, SLV, SLV_W, PUSH, PUSH_W, FIN.
REQ-015 In IDLE, ui_go_wr with ui_go_wdata != 0 SHALL load steps_left = wdata, clear steps_done, go to DEP next cycle; busy high from that next cycle.
REQ-016 In IDLE, ui_go_wr with wdata == 0 SHALL be ignored.
REQ-017 DEP, SLV, PUSH SHALL each last exactly one cycle, assert their start pulse during it, then go to the matching _W state.
REQ-018 Each _W state SHALL advance on its own done input only; done inputs of other phases and done pulses outside the matching _W state SHALL be ignored.
REQ-019 DEP_W on dep_done SHALL go to SLV; SLV_W on slv_done SHALL go to PUSH.
REQ-020 PUSH_W on push_done SHALL decrement steps_left, increment steps_done (same cycle), then go to DEP if the decremented steps_left != 0 and no abort is pending, else FIN.
REQ-021 FIN SHALL last one cycle, pulse run_done, return to IDLE; busy SHALL be low from the IDLE cycle onward.
REQ-022 ui_go_wr while busy with wdata == 0 SHALL set abort_pending; the current timestep SHALL complete through PUSH_W before FIN; steps_left retains its value.
REQ-023 ui_go_wr while busy with wdata != 0 SHALL be ignored, counters unchanged.
REQ-024 A phase timer SHALL clear on entry to each _W state and increment each _W cycle; reaching TIMEOUT_CYCLES without done SHALL set timeout_err and go to FIN.
REQ-025 timeout_err SHALL clear only on rst or on an accepted nonzero go.
REQ-026 Counters SHALL be 32-bit unsigned; steps_done SHALL saturate at 32'hFFFF_FFFF; steps_left never decrements below 0.
REQ-027 At most one start pulse SHALL be high in any cycle; start pulses SHALL never occur in IDLE, _W states, or FIN.
REQ-028 Done arriving in the same cycle as its start pulse SHALL be ignored (counted only from first _W cycle).

Reset
REQ-029 rst SHALL force IDLE, all start pulses 0, busy 0, ui_mem_lock 0, run_done 0, steps_left 0, steps_done 0, timeout_err 0, abort_pending 0, phase timer 0.
REQ-030 rst mid-run SHALL abandon the run without a run_done pulse; done pulses arriving after rst SHALL be ignored.

Verification
REQ-031 go wdata=3, each done returned 5 cycles after its start -> 3 dep/slv/push start triplets in order, steps_done=3, steps_left=0, one run_done, busy low after.
REQ-032 go wdata=10, go wdata=0 during timestep 2 SLV_W -> timestep 2 completes, run_done, steps_done=2, steps_left=8.
REQ-033 TIMEOUT_CYCLES=16, go wdata=1, slv_done withheld -> timeout_err=1 after 16 SLV_W cycles, run_done, no push_start; next go wdata=1 clears timeout_err.
REQ-034 go wdata=2, spurious push_done during DEP_W and dep_done coincident with dep_start -> both ignored; run waits for a later dep_done.
REQ-035 go wdata=5, rst asserted in PUSH_W of timestep 1 -> all outputs at reset values next cycle, no run_done, later push_done ignored.
REQ-036 go wdata=0 in IDLE, and go wdata=7 while busy -> no state change, counters unchanged.
